// File: rtl/div_ctrl_pkg.sv
// Shared divider definitions: default data width and the 2-bit state encoding
// (also consumed by the hazard/stall unit).
package div_ctrl_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BYZERO = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_i / quo_i : current partial remainder and shifting dividend/quotient
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : values after shift, compare and conditional subtract
module div_iter_step
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // Upper part after the shift needs one extra bit: rem may exceed 2^(W-1).
  logic [WIDTH:0] upper;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    upper = {rem_i, quo_i[WIDTH-1]};
    diff  = upper - {1'b0, dvs_i};
    ge    = (upper >= {1'b0, dvs_i});
    // After a successful subtract the result is < divisor, so it fits W bits.
    rem_o = ge ? diff[WIDTH-1:0] : upper[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the EX-stage iterative divider (DIV/DIVU).
//   clk, rst            : clock, async active-high reset
//   div_start           : EX holds a divide instruction
//   div_signed          : 1 = DIV, 0 = DIVU (sampled at accept)
//   opa, opb            : dividend / divisor (sampled at accept)
//   flush               : pipeline flush, aborts any operation
//   stall_req, busy     : combinational status to pipeline control
//   done                : one-cycle result-valid pulse
//   quotient, remainder : registered results, zero while done=0
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             a_neg_c, b_neg_c;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sgn_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sgn_q       <= sgn_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Next-state, datapath and result logic. Results are loaded on the edge
  // into END so that done/quotient/remainder are registered together.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sgn_d       = sgn_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    done_d      = 1'b0;
    quotient_d  = '0;
    remainder_d = '0;
    a_neg_c     = div_signed & opa[WIDTH-1];
    b_neg_c     = div_signed & opb[WIDTH-1];

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            sgn_d   = div_signed;
            neg_a_d = a_neg_c;
            neg_b_d = b_neg_c;
            rem_d   = '0;
            quo_d   = a_neg_c ? (~opa + WIDTH'(1)) : opa;
            dvs_d   = b_neg_c ? (~opb + WIDTH'(1)) : opb;
            cnt_d   = '0;
            state_d = (opb == '0) ? ST_BYZERO : ST_ON;
          end
        end
        ST_BYZERO: begin
          state_d = ST_END;
          done_d  = 1'b1;
        end
        ST_ON: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d     = ST_END;
            done_d      = 1'b1;
            quotient_d  = (sgn_q & (neg_a_q ^ neg_b_q)) ? (~step_quo + WIDTH'(1)) : step_quo;
            remainder_d = (sgn_q & neg_a_q) ? (~step_rem + WIDTH'(1)) : step_rem;
          end
        end
        ST_END: begin
          // div_start still belongs to the finishing instruction here.
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign stall_req = ((state_q == ST_IDLE) & div_start & ~flush)
                   | (state_q == ST_BYZERO)
                   | (state_q == ST_ON);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver pushes expected results from a
// plain-arithmetic reference, an independent monitor pops on done.
`timescale 1ns/1ps
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    else pass_cnt++;
  endtask

  // Reference: truncating division in 64-bit arithmetic; divide-by-zero gives 0/0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    qv = 64'(sa / sb);
    rv = 64'(sa % sb);
    return {qv[31:0], rv[31:0]};
  endfunction

  // Monitor: compares results on done, otherwise results must read zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("quotient", 64'(quotient), 64'(e[63:32]));
          chk("remainder", 64'(remainder), 64'(e[31:0]));
        end
      end else begin
        chk("idle_zero", {quotient, remainder}, 64'd0);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; cycle 0 is the current cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int flush_cyc, input bit keep,
                        input logic [31:0] na, input logic [31:0] nb, input bit ns);
    int lat, cyc;
    bit fin;
    lat = (b == 32'd0) ? 2 : 33;
    opa = a; opb = b; div_signed = s; div_start = 1'b1; flush = 1'b0;
    if (flush_cyc < 0) exp_q.push_back(ref_div(a, b, s));
    cyc = 0; fin = 0;
    while (!fin) begin
      if (cyc == flush_cyc) flush = 1'b1;
      #1;
      chk("stall_active", 64'(stall_req), 64'd1);
      @(posedge clk); cyc++; @(negedge clk);
      if (flush) begin
        flush = 1'b0; div_start = 1'b0;
        #1;
        chk("flush_idle", 64'({busy, stall_req, done}), 64'd0);
        fin = 1;
      end else if (done) begin
        chk("latency", 64'(cyc), 64'(lat));
        chk("stall_end", 64'(stall_req), 64'd0);
        chk("busy_end", 64'(busy), 64'd1);
        if (keep) begin
          opa = na; opb = nb; div_signed = ns;
        end else begin
          div_start = 1'b0;
        end
        fin = 1;
      end else if (cyc > lat + 5) begin
        chk("timeout", 64'(cyc), 64'(lat));
        fin = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; opa = '0; opb = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({stall_req, busy, done, quotient, remainder}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    run_op(32'd5, 32'd0, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    // Flush mid-operation, then a fresh divide completes normally.
    run_op(32'd1000, 32'd3, 1'b0, 10, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("post_flush_idle", 64'({busy, done}), 64'd0);
    run_op(32'd1000, 32'd3, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    // Back-to-back: div_start stays high through END into the next instruction.
    run_op(32'd77, 32'd10, 1'b0, -1, 1'b1, 32'd9, 32'd2, 1'b0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("no_relaunch_in_end", 64'(busy), 64'd0);
    run_op(32'd9, 32'd2, 1'b0, -1, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    // Reset mid-ON clears everything immediately.
    opa = 32'd12345; opb = 32'd11; div_signed = 1'b0; div_start = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1; div_start = 1'b0;
    #1;
    chk("rst_mid_on", 64'({stall_req, busy, done, quotient, remainder}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized operands, mixing zero, small and full-range divisors.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom();
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, -1, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the iterative divider serving DIV/DIVU in the EX stage.
- Accepts operands from the EX operand muxes and runs a radix-2 restoring shift-subtract loop for WIDTH cycles.
- Raises a pipeline stall while busy and returns quotient/remainder for the HI/LO write.
- Aborts cleanly on pipeline flush (exception / eret).

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
div_start  input  1  EX holds a DIV/DIVU; held high by EX for as long as the instruction sits in EX.
div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept.
opa  input  WIDTH  dividend (rs); sampled at accept.
opb  input  WIDTH  divisor (rt); sampled at accept.
flush  input  1  pipeline flush; aborts any operation.
stall_req  output  1  stall request to the pipeline control.
busy  output  1  state != IDLE.
done  output  1  single-cycle result-valid pulse.
quotient  output  WIDTH  to LO; valid only while done=1.
remainder  output  WIDTH  to HI; valid only while done=1.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, partial remainder/quotient registers=0, done=0, quotient=0, remainder=0. stall_req=0 and busy=0 follow combinationally.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - div_start=1 and flush=0 -> accept. Latch div_signed and the operand signs.
  - Latch |opa| and |opb| when signed, raw values when unsigned.
  - opb==0 -> BYZERO; else -> ON with counter=0.
- BYZERO: next cycle -> END with quotient=0, remainder=0.
- ON:
  - Each cycle: shift {rem,quo} left 1; if the upper part is >= divisor, subtract and set the quotient LSB.
  - Counter increments. After the WIDTH-th iteration (counter==WIDTH-1) -> END.
- END:
  - done=1 for exactly one cycle.
  - quotient is negated when signed and the operand signs differ.
  - remainder is negated when signed and the dividend was negative.
  - Next state is IDLE unconditionally.
  - div_start is still high in this cycle (same instruction) and must NOT relaunch; the next accept happens in IDLE on the following cycle, for the next instruction.
- Latency: accept at cycle 0, ON at cycles 1..WIDTH, done at cycle WIDTH+1 (33 for WIDTH=32). Divide-by-zero: done at cycle 2.
- stall_req = (IDLE & div_start & ~flush) | BYZERO | ON. stall_req is 0 in END so the pipeline advances on the done edge.
- flush=1 in any state -> IDLE at the next edge. No done pulse, registers are not committed, and flush overrides div_start in the same cycle.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (magnitude arithmetic is unsigned WIDTH-bit; no trap).
- Result outputs are registered and read as 0 whenever done=0.
- Reset mid-operation: immediate return to the reset values; no partial results leak.

Decomposition:
- Shared package: state encoding constants (IDLE/BYZERO/ON/END as 2-bit values) and the WIDTH default. The hazard/stall unit reuses these.
- One natural sub-module: div_iter_step. Purely combinational single iteration: shift, compare, conditional subtract, next quotient bit.
- FSM, counter, sign fix-up and output registers stay in div_ctrl.

Test Plan:
- DIVU 100 / 7 -> stall_req high for cycles 0..32, done at cycle 33, quotient=14, remainder=2.
- DIV 0xFFFFFF9C (-100) / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, no hang.
- DIVU 5 / 0 -> done at cycle 2, quotient=0, remainder=0, stall_req high in cycles 0..1 only.
- Flush:
  - flush at cycle 10 of a DIVU 1000/3 -> IDLE next cycle, no done, stall_req drops.
  - A new div_start after the flush completes normally with quotient=333, remainder=1.
- Back-to-back:
  - div_start held across END then kept high for a second instruction (9/2) -> the first result pulses once.
  - The second division is accepted the cycle after END and yields quotient=4, remainder=1.
  - Assert rst mid-ON -> all outputs 0 immediately.
